// File: rtl/audio_pkg.sv
// Shared types and helpers for the line-out source selector and peak meter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   SAMPLE_W      default audio sample width
//   sample_t      signed audio sample at the default width
//   xfade_state_e fade controller states
//   sat_abs()     saturating magnitude of a w-bit two's complement value
package audio_pkg;

    localparam int SAMPLE_W = 24;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        FADE_DN = 2'd1,
        MUTED   = 2'd2,
        FADE_UP = 2'd3
    } xfade_state_e;

    // Magnitude of a w-bit sample, presented sign-extended to 64 bits.
    // The most negative code has no positive twin, so it is clamped to
    // 2^(w-1)-1. The result always fits in w-1 bits.
    function automatic logic [63:0] sat_abs(input logic signed [63:0] v,
                                            input int unsigned        w);
        logic [63:0] lim;
        logic [63:0] mag;
        lim = (64'd1 << (w - 1)) - 64'd1;
        mag = v[63] ? 64'(-v) : 64'(v);
        return (mag > lim) ? lim : mag;
    endfunction

endpackage

// File: rtl/audio_peak_meter.sv
// Decaying magnitude peak meter for LED/HEX display of the faded output.
// Latency: peak register updates 1 cycle after each i_vld strobe.
// Backpressure: none; every strobe is consumed.
//
// Ports:
//   i_clk, i_rst  clock and synchronous active-high reset
//   i_data        signed sample, i_vld qualifies it
//   o_peak        held peak magnitude, DATA_W-1 bits
module audio_peak_meter
    import audio_pkg::*;
#(
    parameter int DATA_W          = SAMPLE_W,
    parameter int PEAK_DECAY_LOG2 = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic signed [DATA_W-1:0] i_data,
    input  logic                     i_vld,
    output logic        [DATA_W-2:0] o_peak
);

    localparam int MW = DATA_W - 1;

    logic [MW-1:0] r_peak;
    logic [MW-1:0] w_abs;
    logic [MW-1:0] w_decay;
    logic [MW-1:0] w_next;

    // Saturated magnitude always fits in MW bits, so the cast only drops zeros.
    assign w_abs   = MW'(sat_abs(64'(i_data), DATA_W));
    // Exponential decay: lose 1/2^PEAK_DECAY_LOG2 of the held value per sample.
    assign w_decay = r_peak - (r_peak >> PEAK_DECAY_LOG2);
    assign w_next  = (w_abs > w_decay) ? w_abs : w_decay;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_peak <= '0;
        end else if (i_vld) begin
            r_peak <= w_next;
        end
    end

    assign o_peak = r_peak;

endmodule

// File: rtl/audio_src_xfade.sv
// Click-free N-way line-out source selector with linear gain ramps and peak meter.
// Latency: 2 cycles from sample_valid_i to valid_o/data_o; peak_o 1 cycle later.
// Backpressure: none; one strobe per sample, back-to-back strobes are legal.
//
// Ports:
//   clk_i, rst_i     clock and synchronous active-high reset
//   sample_valid_i   one strobe per audio sample
//   src_data_i       packed sources, source k at [k*DATA_W +: DATA_W]
//   sel_i, mute_i    requested source (out-of-range -> 0) and mute request
//   data_o, valid_o  faded sample and its strobe
//   active_src_o     source currently routed
//   busy_o           high while a fade is pending or in progress
//   peak_o           decaying magnitude peak of data_o
module audio_src_xfade
    import audio_pkg::*;
#(
    parameter int DATA_W          = SAMPLE_W,
    parameter int N_SRC           = 4,
    parameter int RAMP_LOG2       = 6,
    parameter int PEAK_DECAY_LOG2 = 8
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        sample_valid_i,
    input  logic [N_SRC*DATA_W-1:0]     src_data_i,
    input  logic [$clog2(N_SRC)-1:0]    sel_i,
    input  logic                        mute_i,
    output logic [DATA_W-1:0]           data_o,
    output logic                        valid_o,
    output logic [$clog2(N_SRC)-1:0]    active_src_o,
    output logic                        busy_o,
    output logic [DATA_W-2:0]           peak_o
);

    localparam int SW = $clog2(N_SRC);
    localparam int GW = RAMP_LOG2 + 1;              // gain spans 0..FULL inclusive
    localparam int PW = DATA_W + RAMP_LOG2 + 1;     // product width, no overflow
    localparam logic [GW-1:0] FULL = GW'(1) << RAMP_LOG2;

    // Control state
    xfade_state_e      r_state;
    logic [GW-1:0]     r_g;
    logic [SW-1:0]     r_active;
    logic [SW-1:0]     r_target;

    // Datapath pipeline
    logic signed [DATA_W-1:0] r_x;      // stage 1: routed sample
    logic [GW-1:0]            r_xg;     // stage 1: gain in force for that sample
    logic                     r_v1;
    logic [DATA_W-1:0]        r_data;   // stage 2: faded sample
    logic                     r_vld;

    logic [DATA_W-1:0]        w_srcs [N_SRC];
    logic [SW-1:0]            w_sel;
    logic                     w_redirect;
    logic signed [PW-1:0]     w_x_ext;
    logic signed [PW-1:0]     w_g_ext;
    logic signed [PW-1:0]     w_prod;
    logic [DATA_W-1:0]        w_y;

    for (genvar k = 0; k < N_SRC; k++) begin : g_src
        assign w_srcs[k] = src_data_i[k*DATA_W +: DATA_W];
    end

    // Unused encodings of sel_i fall back to source 0.
    assign w_sel = (32'(sel_i) >= N_SRC) ? '0 : sel_i;

    // Any request that needs the current source taken down first.
    assign w_redirect = mute_i || (w_sel != r_active);

    // Gain is unsigned; zero-extend it before the signed multiply so that
    // FULL (MSB set) is not read as negative.
    assign w_x_ext = PW'(r_x);
    assign w_g_ext = signed'(PW'(r_xg));
    assign w_prod  = w_x_ext * w_g_ext;
    assign w_y     = DATA_W'(w_prod >>> RAMP_LOG2);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= FADE_UP;
            r_g      <= '0;
            r_active <= '0;
            r_target <= '0;
            r_x      <= '0;
            r_xg     <= '0;
            r_v1     <= 1'b0;
            r_data   <= '0;
            r_vld    <= 1'b0;
        end else begin
            r_v1  <= sample_valid_i;
            r_vld <= r_v1;
            if (r_v1) begin
                r_data <= w_y;
            end

            if (sample_valid_i) begin
                // The sample is scaled by the gain from before this update.
                r_x  <= signed'(w_srcs[r_active]);
                r_xg <= r_g;

                unique case (r_state)
                    RUN: begin
                        if (w_redirect) begin
                            r_state  <= FADE_DN;
                            r_target <= w_sel;
                        end
                    end

                    FADE_DN: begin
                        // Later sel changes only retarget; the ramp carries on.
                        r_target <= w_sel;
                        // g may already be 0 if a fade-up was interrupted at
                        // its very start, so treat <=1 as arriving at silence.
                        if (r_g <= GW'(1)) begin
                            r_g      <= '0;
                            r_active <= r_target;
                            r_state  <= mute_i ? MUTED : FADE_UP;
                        end else begin
                            r_g <= r_g - GW'(1);
                        end
                    end

                    MUTED: begin
                        r_g <= '0;
                        if (!mute_i) begin
                            r_active <= w_sel;
                            r_target <= w_sel;
                            r_state  <= FADE_UP;
                        end
                    end

                    FADE_UP: begin
                        // Reversing holds g for this sample, so the way down
                        // starts exactly where the way up stopped.
                        if (w_redirect) begin
                            r_state  <= FADE_DN;
                            r_target <= w_sel;
                        end else if (r_g >= FULL - GW'(1)) begin
                            r_g     <= FULL;
                            r_state <= RUN;
                        end else begin
                            r_g <= r_g + GW'(1);
                        end
                    end

                    default: begin
                        r_state <= FADE_UP;
                    end
                endcase
            end
        end
    end

    audio_peak_meter #(
        .DATA_W          (DATA_W),
        .PEAK_DECAY_LOG2 (PEAK_DECAY_LOG2)
    ) u_peak (
        .i_clk  (clk_i),
        .i_rst  (rst_i),
        .i_data (signed'(r_data)),
        .i_vld  (r_vld),
        .o_peak (peak_o)
    );

    assign data_o       = r_data;
    assign valid_o      = r_vld;
    assign active_src_o = r_active;
    assign busy_o       = (r_state != RUN);

endmodule
